// File: rtl/hdmi_sched_pkg.sv
// hdmi_sched_pkg
//   Shared definitions for the HDMI data-island packet scheduler:
//   source index constants, FSM state enum, null-packet constants and
//   the saturating burst-counter helper.
package hdmi_sched_pkg;

  localparam logic [2:0] SRC_NULL  = 3'd0;
  localparam logic [2:0] SRC_ACR   = 3'd1;
  localparam logic [2:0] SRC_AUDIO = 3'd2;
  localparam logic [2:0] SRC_AVI   = 3'd3;
  localparam logic [2:0] SRC_AIF   = 3'd4;
  localparam logic [2:0] SRC_SPD   = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [23:0]       NULL_HEADER = 24'h000000;
  localparam logic [3:0][55:0]  NULL_SUB    = 224'h0;

  // Saturating increment of the audio burst counter.
  function automatic logic [3:0] burst_next(input logic [3:0] cnt,
                                            input logic [3:0] max_cnt);
    if (cnt >= max_cnt) begin
      return max_cnt;
    end else begin
      return cnt + 4'd1;
    end
  endfunction

endpackage

// File: rtl/hdmi_sched_arbiter.sv
// hdmi_sched_arbiter
//   Combinational winner selection for one data-island slot.
//   Priority: ACR > audio > AVI > Audio InfoFrame > SPD > null, except that
//   audio yields to the highest pending InfoFrame once burst_cnt has reached
//   MAX_AUDIO_BURST.
// Ports:
//   acr_pend, audio_pend, avi_pend, aif_pend, spd_pend : pending requests
//   burst_cnt : consecutive audio acceptances (saturating)
//   winner    : selected source index (SRC_NULL when nothing is pending)
module hdmi_sched_arbiter
  import hdmi_sched_pkg::*;
#(
  parameter int MAX_AUDIO_BURST = 4
) (
  input  logic       acr_pend,
  input  logic       audio_pend,
  input  logic       avi_pend,
  input  logic       aif_pend,
  input  logic       spd_pend,
  input  logic [3:0] burst_cnt,
  output logic [2:0] winner
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_AUDIO_BURST);

  logic [2:0] lower_s;
  logic       burst_full_s;

  assign burst_full_s = (burst_cnt == BURST_MAX);

  // Highest-priority InfoFrame source; also the fallback when audio is idle.
  always_comb begin
    lower_s = SRC_NULL;
    if (avi_pend) begin
      lower_s = SRC_AVI;
    end else if (aif_pend) begin
      lower_s = SRC_AIF;
    end else if (spd_pend) begin
      lower_s = SRC_SPD;
    end else begin
      lower_s = SRC_NULL;
    end
  end

  // ACR always wins; audio wins unless its burst allowance is used up while
  // an InfoFrame is waiting.
  always_comb begin
    winner = SRC_NULL;
    if (acr_pend) begin
      winner = SRC_ACR;
    end else if (audio_pend && !(burst_full_s && (lower_s != SRC_NULL))) begin
      winner = SRC_AUDIO;
    end else begin
      winner = lower_s;
    end
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// hdmi_packet_scheduler
//   Arbitrates the HDMI data-island packet slot among ACR, audio sample,
//   AVI InfoFrame, Audio InfoFrame and (optionally) SPD InfoFrame sources.
//   Each slot is chosen in IDLE, registered and held stable in HOLD until the
//   serializer accepts it (pkt_valid && pkt_ready).
// Configuration:
//   HDMI_SCHED_SPD_EN : when defined, source 5 (SPD) participates and its
//                       request is re-armed by frame_start; otherwise source 5
//                       inputs are ignored and never selected.
// Ports:
//   clk_pixel, reset        : pixel clock, async active-high reset
//   frame_start, acr_tick   : request pulses (InfoFrames / ACR)
//   audio_req, audio_ack    : audio level request / acceptance pulse
//   src_header, src_sub     : per-source packet contents (index 1..5)
//   pkt_valid, pkt_ready    : handshake to the packet serializer
//   pkt_src, pkt_header, pkt_sub : offered packet
//   info_missed, acr_overrun: registered error pulses
module hdmi_packet_scheduler
  import hdmi_sched_pkg::*;
#(
  parameter int MAX_AUDIO_BURST = 4
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  acr_tick,
  input  logic                  audio_req,
  output logic                  audio_ack,
  input  logic [5:1][23:0]      src_header,
  input  logic [5:1][3:0][55:0] src_sub,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [2:0]            pkt_src,
  output logic [23:0]           pkt_header,
  output logic [3:0][55:0]      pkt_sub,
  output logic                  info_missed,
  output logic                  acr_overrun
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             offer_s;
  logic             accept_s;

  logic             acr_p_r;
  logic             avi_p_r;
  logic             aif_p_r;
  logic             spd_pend_s;
  logic [3:0]       burst_cnt_r;

  logic [2:0]       winner_s;
  logic [23:0]      win_header_s;
  logic [3:0][55:0] win_sub_s;

  logic             pkt_valid_r;
  logic [2:0]       pkt_src_r;
  logic [23:0]      pkt_header_r;
  logic [3:0][55:0] pkt_sub_r;
  logic             info_missed_r;
  logic             acr_overrun_r;

  localparam logic [3:0] BURST_MAX = 4'(MAX_AUDIO_BURST);

  hdmi_sched_arbiter #(
    .MAX_AUDIO_BURST (MAX_AUDIO_BURST)
  ) u_arbiter (
    .acr_pend   (acr_p_r),
    .audio_pend (audio_req),
    .avi_pend   (avi_p_r),
    .aif_pend   (aif_p_r),
    .spd_pend   (spd_pend_s),
    .burst_cnt  (burst_cnt_r),
    .winner     (winner_s)
  );

  // FSM state register.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: IDLE always offers a packet, HOLD waits for acceptance.
  always_comb begin
    state_nxt_s = state_r;
    offer_s     = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        offer_s     = 1'b1;
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (pkt_ready) begin
          accept_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Winner's packet contents; unselected or disabled sources yield the null packet.
  always_comb begin
    win_header_s = NULL_HEADER;
    win_sub_s    = NULL_SUB;
    case (winner_s)
      SRC_ACR: begin
        win_header_s = src_header[1];
        win_sub_s    = src_sub[1];
      end
      SRC_AUDIO: begin
        win_header_s = src_header[2];
        win_sub_s    = src_sub[2];
      end
      SRC_AVI: begin
        win_header_s = src_header[3];
        win_sub_s    = src_sub[3];
      end
      SRC_AIF: begin
        win_header_s = src_header[4];
        win_sub_s    = src_sub[4];
      end
`ifdef HDMI_SCHED_SPD_EN
      SRC_SPD: begin
        win_header_s = src_header[5];
        win_sub_s    = src_sub[5];
      end
`endif
      default: begin
        win_header_s = NULL_HEADER;
        win_sub_s    = NULL_SUB;
      end
    endcase
  end

  // Output packet registers: loaded in IDLE, frozen through HOLD.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      pkt_valid_r  <= 1'b0;
      pkt_src_r    <= SRC_NULL;
      pkt_header_r <= NULL_HEADER;
      pkt_sub_r    <= NULL_SUB;
    end else if (offer_s) begin
      pkt_valid_r  <= 1'b1;
      pkt_src_r    <= winner_s;
      pkt_header_r <= win_header_s;
      pkt_sub_r    <= win_sub_s;
    end else if (accept_s) begin
      pkt_valid_r  <= 1'b0;
    end else begin
      pkt_valid_r  <= pkt_valid_r;
    end
  end

  // Pending flags; a new pulse in the acceptance cycle keeps the flag set.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      acr_p_r <= 1'b0;
      avi_p_r <= 1'b1;
      aif_p_r <= 1'b1;
    end else begin
      if (acr_tick) begin
        acr_p_r <= 1'b1;
      end else if (accept_s && (pkt_src_r == SRC_ACR)) begin
        acr_p_r <= 1'b0;
      end else begin
        acr_p_r <= acr_p_r;
      end
      if (frame_start) begin
        avi_p_r <= 1'b1;
        aif_p_r <= 1'b1;
      end else begin
        if (accept_s && (pkt_src_r == SRC_AVI)) begin
          avi_p_r <= 1'b0;
        end else begin
          avi_p_r <= avi_p_r;
        end
        if (accept_s && (pkt_src_r == SRC_AIF)) begin
          aif_p_r <= 1'b0;
        end else begin
          aif_p_r <= aif_p_r;
        end
      end
    end
  end

`ifdef HDMI_SCHED_SPD_EN
  logic spd_p_r;

  // SPD pending flag, re-armed every frame like the other InfoFrames.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      spd_p_r <= 1'b1;
    end else if (frame_start) begin
      spd_p_r <= 1'b1;
    end else if (accept_s && (pkt_src_r == SRC_SPD)) begin
      spd_p_r <= 1'b0;
    end else begin
      spd_p_r <= spd_p_r;
    end
  end

  assign spd_pend_s = spd_p_r;
`else
  logic spd_unused_s;

  assign spd_pend_s   = 1'b0;
  // Source 5 inputs have no consumer in this build.
  assign spd_unused_s = ^{src_header[5], src_sub[5]};
`endif

  // Audio burst counter: counts audio acceptances, ACR is transparent,
  // any other accepted source (including null) restarts the burst.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      burst_cnt_r <= 4'd0;
    end else if (accept_s) begin
      if (pkt_src_r == SRC_AUDIO) begin
        burst_cnt_r <= burst_next(burst_cnt_r, BURST_MAX);
      end else if (pkt_src_r == SRC_ACR) begin
        burst_cnt_r <= burst_cnt_r;
      end else begin
        burst_cnt_r <= 4'd0;
      end
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end

  // Error pulses, judged against the flags as they stood when the pulse arrived.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      info_missed_r <= 1'b0;
      acr_overrun_r <= 1'b0;
    end else begin
      info_missed_r <= frame_start && (avi_p_r || aif_p_r);
      acr_overrun_r <= acr_tick && acr_p_r;
    end
  end

  assign audio_ack   = accept_s && (pkt_src_r == SRC_AUDIO);
  assign pkt_valid   = pkt_valid_r;
  assign pkt_src     = pkt_src_r;
  assign pkt_header  = pkt_header_r;
  assign pkt_sub     = pkt_sub_r;
  assign info_missed = info_missed_r;
  assign acr_overrun = acr_overrun_r;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
module tb_hdmi_packet_scheduler;

  localparam int MAXB = 4;
`ifdef HDMI_SCHED_SPD_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif

  logic                  clk_pixel = 1'b0;
  logic                  reset;
  logic                  frame_start, acr_tick, audio_req, pkt_ready;
  logic                  audio_ack, pkt_valid, info_missed, acr_overrun;
  logic [5:1][23:0]      hdr;
  logic [5:1][3:0][55:0] sub;
  logic [2:0]            pkt_src;
  logic [23:0]           pkt_header;
  logic [3:0][55:0]      pkt_sub;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_valid;
  int          m_src;
  logic [23:0] m_hdr;
  logic [223:0] m_sub;
  bit          m_acr, m_avi, m_aif, m_spd, m_missed, m_over;
  int          m_burst;

  int dut_acc[$];
  int dut_miss_cnt, dut_over_cnt;

  hdmi_packet_scheduler #(.MAX_AUDIO_BURST(MAXB)) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .frame_start (frame_start),
    .acr_tick    (acr_tick),
    .audio_req   (audio_req),
    .audio_ack   (audio_ack),
    .src_header  (hdr),
    .src_sub     (sub),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_src     (pkt_src),
    .pkt_header  (pkt_header),
    .pkt_sub     (pkt_sub),
    .info_missed (info_missed),
    .acr_overrun (acr_overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_valid = 1'b0; m_src = 0; m_hdr = 24'h0; m_sub = 224'h0;
    m_acr = 1'b0; m_avi = 1'b1; m_aif = 1'b1; m_spd = SPD_EN;
    m_burst = 0; m_missed = 1'b0; m_over = 1'b0;
  endtask

  // Winner from the rules: list pending sources by priority, skip audio when
  // its burst is spent and an InfoFrame waits behind it.
  function automatic int pick(input bit areq);
    int cand[$];
    if (m_acr) cand.push_back(1);
    if (areq)  cand.push_back(2);
    if (m_avi) cand.push_back(3);
    if (m_aif) cand.push_back(4);
    if (m_spd) cand.push_back(5);
    if (cand.size() == 0) return 0;
    if (cand[0] == 2 && m_burst == MAXB && cand.size() > 1) return cand[1];
    return cand[0];
  endfunction

  function automatic int acc_at(input int i);
    if (i < dut_acc.size()) return dut_acc[i];
    return -1;
  endfunction

  function automatic int nth_nonzero(input int i);
    int k = 0;
    foreach (dut_acc[x]) begin
      if (dut_acc[x] != 0) begin
        if (k == i) return dut_acc[x];
        k++;
      end
    end
    return -1;
  endfunction

  function automatic int count_src(input int s);
    int c = 0;
    foreach (dut_acc[x]) if (dut_acc[x] == s) c++;
    return c;
  endfunction

  function automatic int audio_before_avi();
    int c = 0;
    foreach (dut_acc[x]) begin
      if (dut_acc[x] == 3) return c;
      if (dut_acc[x] == 2) c++;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    check("pkt_valid",   224'(pkt_valid),   224'(m_valid));
    check("pkt_src",     224'(pkt_src),     224'(m_src));
    check("pkt_header",  224'(pkt_header),  224'(m_hdr));
    check("pkt_sub",     pkt_sub,           m_sub);
    check("info_missed", 224'(info_missed), 224'(m_missed));
    check("acr_overrun", 224'(acr_overrun), 224'(m_over));
  endtask

  // One clock cycle: drive inputs, check ack, clock, advance model, check outputs.
  task automatic step(input bit fs, input bit tk, input bit aq, input bit rdy);
    logic [63:0] t64;
    bit acc;
    int w;
    frame_start = fs; acr_tick = tk; audio_req = aq; pkt_ready = rdy;
    for (int s = 1; s <= 5; s++) begin
      hdr[s] = 24'($urandom());
      for (int j = 0; j < 4; j++) begin
        t64 = {$urandom(), $urandom()};
        sub[s][j] = t64[55:0];
      end
    end
    #1;
    acc = m_valid && rdy;
    check("audio_ack", 224'(audio_ack), 224'(acc && (m_src == 2)));
    if (pkt_valid && pkt_ready) dut_acc.push_back(int'(pkt_src));
    @(posedge clk_pixel); #1;
    m_missed = fs && (m_avi || m_aif);
    m_over   = tk && m_acr;
    if (acc) begin
      case (m_src)
        1: m_acr = 1'b0;
        3: m_avi = 1'b0;
        4: m_aif = 1'b0;
        5: m_spd = 1'b0;
        default: ;
      endcase
      if (m_src == 2) m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
      else if (m_src != 1) m_burst = 0;
      m_valid = 1'b0;
    end else if (!m_valid) begin
      w = pick(aq);
      m_valid = 1'b1;
      m_src = w;
      m_hdr = (w == 0) ? 24'h0 : hdr[w];
      m_sub = (w == 0) ? 224'h0 : sub[w];
    end
    if (fs) begin
      m_avi = 1'b1; m_aif = 1'b1;
      if (SPD_EN) m_spd = 1'b1;
    end
    if (tk) m_acr = 1'b1;
    dut_miss_cnt += int'(info_missed);
    dut_over_cnt += int'(acr_overrun);
    check_outputs();
  endtask

  initial begin
    int exp2[6];
    int held_exp;
    bit found;
    exp2 = '{2, 2, 2, 2, 3, 2};
    reset = 1'b1; frame_start = 1'b0; acr_tick = 1'b0; audio_req = 1'b0;
    pkt_ready = 1'b0; hdr = '0; sub = '0;
    mreset();
    #3;
    check_outputs();
    check("reset_ack", 224'(audio_ack), 224'(0));
    @(posedge clk_pixel); #1;
    reset = 1'b0;

    // Test 1: after reset, AVI then Audio InfoFrame then null packets.
    dut_acc.delete();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    check("t1_first_avi", 224'(acc_at(0)), 224'(3));
    check("t1_then_aif",  224'(acc_at(1)), 224'(4));
    check("t1_then_null", 224'(acc_at(2)), 224'(0));

    // Test 2: audio burst of four, then AVI, then audio resumes.
    dut_acc.delete();
    step(1, 0, 1, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) check($sformatf("t2_seq%0d", i), 224'(nth_nonzero(i)), 224'(exp2[i]));

    // Test 3: ACR during an audio burst goes ahead and does not disturb the count.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    dut_acc.delete();
    step(1, 0, 1, 1);
    for (int i = 0; i < 19; i++) step(0, (i == 3), 1, 1);
    check("t3_acr_once",     224'(count_src(1)),      224'(1));
    check("t3_audio_burst",  224'(audio_before_avi()), 224'(MAXB));

    // Test 4: two ACR ticks before acceptance -> one overrun, one ACR packet.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    dut_acc.delete(); dut_over_cnt = 0;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    check("t4_overrun_once", 224'(dut_over_cnt),  224'(1));
    check("t4_acr_once",     224'(count_src(1)),  224'(1));

    // Test 5: long stall; audio rises meanwhile and waits for the next slot.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    held_exp = m_src;
    for (int i = 0; i < 100; i++) step(0, 0, (i >= 10), 0);
    dut_acc.delete();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    check("t5_held_first", 224'(acc_at(0)), 224'(held_exp));
    check("t5_then_audio", 224'(acc_at(1)), 224'(2));

    // Test 6: frame_start coinciding with AVI acceptance.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid && m_src == 3) begin
        found = 1'b1;
        break;
      end
      step(0, 0, 0, 1);
    end
    check("t6_avi_offered", 224'(found), 224'(1));
    dut_acc.delete(); dut_miss_cnt = 0;
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    check("t6_avi",       224'(acc_at(0)),    224'(3));
    check("t6_avi_again", 224'(acc_at(1)),    224'(3));
    check("t6_aif",       224'(acc_at(2)),    224'(4));
    check("t6_missed",    224'(dut_miss_cnt), 224'(1));

    // Reset in the middle of HOLD drops pkt_valid at once, no ack.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    pkt_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_valid_drop", 224'(pkt_valid), 224'(0));
    check("rst_no_ack",     224'(audio_ack), 224'(0));
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    mreset();
    check_outputs();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
